bus_arbit_rr: RTL and testbench

BUS_ARBIT_RR -- requirements
Module: bus_arbit_rr

---
 rtl/bus_arbit_rr.sv | 151 +++++++++++++++
 tb/tb_bus_arbit_rr.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbit_rr.sv
// Round-robin bus arbiter with registered one-hot grant; optional tenure limit via BUS_ARBIT_RR_TENURE_EN.
// Latency: one cycle from request to grant. An owner keeps the bus until it drops its request.
module bus_arbit_rr #(
    parameter  int NUM_M      = 4,
    parameter  int MAX_TENURE = 16,
    localparam int IDW        = $clog2(NUM_M)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] m_req,
    output logic [NUM_M-1:0] m_grant,
    output logic [IDW-1:0]   m_grant_id,
    output logic             bus_busy
);

    if (NUM_M < 2 || NUM_M > 16) begin : g_bad_num_m
        $error("bus_arbit_rr: NUM_M out of range 2..16");
    end
    if (MAX_TENURE < 2 || MAX_TENURE > 255) begin : g_bad_tenure
        $error("bus_arbit_rr: MAX_TENURE out of range 2..255");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_M-1:0]   grant_q, grant_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     last_q, last_d;
    logic               busy_q, busy_d;

    logic [NUM_M-1:0]   req_s;
    logic [NUM_M-1:0]   cand;
    logic               force_rel;
    logic               arb;
    logic               win_vld;
    logic [IDW-1:0]     win_id;

    // Unknown request bits must never be able to win the scan.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (m_req[i] == 1'b1) begin
                req_s[i] = 1'b1;
            end
        end
    end

`ifdef BUS_ARBIT_RR_TENURE_EN
    logic [7:0] ten_q, ten_d;
    logic       ten_full;
    logic       others_req;

    always_comb begin
        others_req = |(req_s & ~grant_q);
        ten_full   = (ten_q == 8'(MAX_TENURE - 1));
        force_rel  = (state_q == ST_OWN) && req_s[id_q] && ten_full && others_req;
    end

    // Clears on every new grant, counts while owned, saturates when nobody else waits.
    always_comb begin
        ten_d = ten_q;
        if (arb) begin
            ten_d = 8'd0;
        end else if (state_q == ST_OWN && !ten_full) begin
            ten_d = ten_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ten_q <= 8'd0;
        end else begin
            ten_q <= ten_d;
        end
    end
`else
    always_comb begin
        force_rel = 1'b0;
    end
`endif

    // Scan starts just past the last owner; a forced release masks the current owner.
    always_comb begin
        cand = req_s;
        if (force_rel) begin
            cand[id_q] = 1'b0;
        end
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            automatic int       idx;
            automatic logic [IDW-1:0] idx_w;
            idx = int'(last_q) + k;
            if (idx >= NUM_M) begin
                idx = idx - NUM_M;
            end
            idx_w = IDW'(idx);
            if (!win_vld && cand[idx_w]) begin
                win_vld = 1'b1;
                win_id  = idx_w;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        last_d  = last_q;
        busy_d  = busy_q;
        arb     = (state_q == ST_IDLE) || !req_s[id_q] || force_rel;
        if (arb) begin
            if (win_vld) begin
                state_d         = ST_OWN;
                grant_d         = '0;
                grant_d[win_id] = 1'b1;
                id_d            = win_id;
                last_d          = win_id;
                busy_d          = 1'b1;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            last_q  <= IDW'(NUM_M - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign m_grant    = grant_q;
    assign m_grant_id = id_q;
    assign bus_busy   = busy_q;

endmodule

// File: tb/tb_bus_arbit_rr.sv
// Bench for bus_arbit_rr: directed scenarios with literal expectations plus a randomized run against a reference model.
module tb_bus_arbit_rr;
    localparam int N  = 4;
    localparam int MT = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] m_req = '0;
    logic [N-1:0] m_grant;
    logic [1:0]   m_grant_id;
    logic         bus_busy;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: current owner (-1 when idle), last owner, last reported id, cycles held.
    int own  = -1;
    int last = N - 1;
    int gid  = 0;
    int held = 0;

    bus_arbit_rr #(.NUM_M(N), .MAX_TENURE(MT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m_req      (m_req),
        .m_grant    (m_grant),
        .m_grant_id (m_grant_id),
        .bus_busy   (bus_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) begin
            own = -1; last = N - 1; gid = 0; held = 0;
        end else begin
            bit arb, excl;
            int w;
            arb  = (own < 0) || !m_req[own];
            excl = 1'b0;
`ifdef BUS_ARBIT_RR_TENURE_EN
            if (!arb && held >= MT && ((m_req & ~(4'(1) << own)) != 0)) begin
                arb = 1'b1; excl = 1'b1;
            end
`endif
            if (arb) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (last + k) % N;
                    if (w < 0 && m_req[i] && !(excl && i == own)) w = i;
                end
                if (w >= 0) begin
                    own = w; last = w; gid = w; held = 1;
                end else begin
                    own = -1;
                end
            end else begin
                held++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_grant", int'(m_grant), (own >= 0) ? (1 << own) : 0);
            check("model_id",    int'(m_grant_id), gid);
            check("model_busy",  int'(bus_busy), (own >= 0) ? 1 : 0);
        end
    end

    // Called at a negedge: drive request, let one rising edge pass, return at the next negedge.
    task automatic cyc(input logic [N-1:0] r);
        m_req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        reset_n = 1'b0;
        cyc(r);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_seq [5];
        logic [N-1:0] r;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

        @(negedge clk);
        do_reset('0);
        chk_en = 1'b1;
        check("rst_grant", int'(m_grant), 0);
        check("rst_id",    int'(m_grant_id), 0);
        check("rst_busy",  int'(bus_busy), 0);

        // Single requester grant and release.
        cyc(4'b0001);
        check("s1_grant", int'(m_grant), 4'b0001);
        check("s1_id",    int'(m_grant_id), 0);
        check("s1_busy",  int'(bus_busy), 1);
        cyc(4'b0000);
        check("s1_rel_grant", int'(m_grant), 0);
        check("s1_rel_busy",  int'(bus_busy), 0);

        // Rotation with each owner dropping for one cycle.
        do_reset('0);
        cyc(4'b1111);
        check("rr_0", int'(m_grant), int'(exp_seq[0]));
        for (int i = 1; i < 5; i++) begin
            cyc(4'b1111 & ~m_grant);
            check("rr_seq", int'(m_grant), int'(exp_seq[i]));
        end

        // Master 1 holds while master 3 waits.
        do_reset('0);
        cyc(4'b0010);
        check("ten_first", int'(m_grant), 4'b0010);
        for (int i = 1; i <= 6; i++) begin
            cyc(4'b1010);
`ifdef BUS_ARBIT_RR_TENURE_EN
            check("ten_on", int'(m_grant), (i <= 3) ? 4'b0010 : 4'b1000);
`else
            check("ten_off", int'(m_grant), 4'b0010);
`endif
        end

        // Lone requester keeps the bus indefinitely.
        do_reset('0);
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0100);
            check("solo", int'(m_grant), 4'b0100);
        end

        // Reset in the middle of a tenure.
        do_reset('0);
        cyc(4'b1111);
        cyc(4'b1111);
        cyc(4'b1111);
        do_reset(4'b1111);
        check("mid_rst_grant", int'(m_grant), 0);
        check("mid_rst_busy",  int'(bus_busy), 0);
        check("mid_rst_id",    int'(m_grant_id), 0);
        cyc(4'b1111);
        check("mid_rst_first", int'(m_grant), 4'b0001);

        // Randomized traffic; long holds exercise the tenure limit.
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(N'($urandom));
            end else begin
                if ($urandom_range(0, 3) == 0) r = N'($urandom);
                cyc(r);
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
